seg_scan_receiver: RTL

//   Receive end of the multiplexed 4-digit 7-segment scan bus driven by the game top level.

---
 rtl/seg_scan_receiver.sv | 120 ++++++++++++
 1 files changed

// File: rtl/seg_scan_receiver.sv
// seg_scan_receiver: rebuilds a 4-digit BCD frame from a multiplexed, active-low 7-segment scan bus
//   clk           system clock
//   reset         asynchronous active-low reset
//   scan_sel      digit enables, active-low one-hot (bit0 = timer_ones .. bit3 = score_tens)
//   scan_seg      segments a..g on bits 0..6, active-low
//   digits_out    {d3,d2,d1,d0} BCD, updated on frame completion
//   digit_valid   per-digit "captured with a legal pattern"
//   frame_done    one-cycle pulse when digits_out updates
//   seg_error     one-cycle pulse on an illegal select or segment pattern at capture
//   link_timeout  high while the link is down
module seg_scan_receiver #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  scan_sel,
    input  logic [6:0]  scan_seg,
    output logic [15:0] digits_out,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        seg_error,
    output logic        link_timeout
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic {COLLECT, LINK_DOWN} state_t;
    state_t        state;
    logic [10:0]   sync1, sync2, prev;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [15:0]   shadow, merged;
    logic [3:0]    mask, sel, bcd, mask_next;
    logic [6:0]    seg_ag;
    logic [1:0]    idx;
    logic          capture, blank, sel_ok, seg_ok, legal_cap;
    assign sel       = sync2[10:7];
    // reorder so the literal patterns below read a..g from left to right
    assign seg_ag    = {sync2[0], sync2[1], sync2[2], sync2[3], sync2[4], sync2[5], sync2[6]};
    // fires only on the cycle the count steps onto SETTLE_CYCLES, so a long window captures once
    assign capture   = (sync2 == prev) && (settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign blank     = &sel;
    assign sel_ok    = $onehot(~sel);
    assign idx       = ~sel[0] ? 2'd0 : ~sel[1] ? 2'd1 : ~sel[2] ? 2'd2 : 2'd3;
    assign mask_next = mask | (4'b0001 << idx);
    assign legal_cap = capture && sel_ok && seg_ok;
    always_comb begin
        seg_ok = 1'b1;
        bcd = 4'd0;
        case (seg_ag)
            7'b0000001: bcd = 4'd0;
            7'b1001111: bcd = 4'd1;
            7'b0010010: bcd = 4'd2;
            7'b0000110: bcd = 4'd3;
            7'b1001100: bcd = 4'd4;
            7'b0100100: bcd = 4'd5;
            7'b0100000: bcd = 4'd6;
            7'b0001111: bcd = 4'd7;
            7'b0000000: bcd = 4'd8;
            7'b0000100: bcd = 4'd9;
            default:    seg_ok = 1'b0;
        endcase
    end
    always_comb begin
        merged = shadow;
        merged[{idx, 2'b00} +: 4] = bcd;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1        <= '1;
            sync2        <= '1;
            prev         <= '1;
            settle_cnt   <= '0;
            timeout_cnt  <= '0;
            shadow       <= '0;
            mask         <= '0;
            digits_out   <= '0;
            digit_valid  <= '0;
            frame_done   <= 1'b0;
            seg_error    <= 1'b0;
            link_timeout <= 1'b0;
            state        <= COLLECT;
        end else begin
            sync1      <= {scan_sel, scan_seg};
            sync2      <= sync1;
            prev       <= sync2;
            settle_cnt <= (sync2 != prev) ? '0 : (settle_cnt == SW'(SETTLE_CYCLES)) ? settle_cnt : settle_cnt + 1'b1;
            frame_done <= 1'b0;
            seg_error  <= 1'b0;
            if (legal_cap) begin
                // a legal capture also brings the link back up and counts toward the new frame
                shadow           <= merged;
                digit_valid[idx] <= 1'b1;
                timeout_cnt      <= '0;
                state            <= COLLECT;
                link_timeout     <= 1'b0;
                mask             <= (mask_next == 4'hF) ? 4'h0 : mask_next;
                if (mask_next == 4'hF) begin
                    digits_out <= merged;
                    frame_done <= 1'b1;
                end
            end else begin
                if (state == COLLECT && timeout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state        <= LINK_DOWN;
                    link_timeout <= 1'b1;
                    mask         <= '0;
                    digit_valid  <= '0;
                    timeout_cnt  <= '0;
                end else if (state == COLLECT) begin
                    timeout_cnt <= (timeout_cnt == TW'(TIMEOUT_CYCLES)) ? timeout_cnt : timeout_cnt + 1'b1;
                end
                if (capture && !blank) begin
                    seg_error <= 1'b1;
                    if (sel_ok)
                        digit_valid[idx] <= 1'b0;
                end
            end
        end
    end
endmodule
